port_info_table: RTL and testbench
==================================

PORT_INFO_TABLE -- requirements
Module: port_info_table

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning number of channel entries (2..64).
REQ-002 SHALL have parameter PORT_W, default 4, meaning width of each entry's port_num field.
REQ-003 SHALL have parameter DEFAULT_PORT, default 0, meaning port_num value loaded by reset and by clear.
REQ-004 SHALL define CHW = max(1, clog2(NUM_CH)) and CNTW = clog2(NUM_CH+1) as derived widths.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port res, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port wr_valid, input, 1, write request.
REQ-008 SHALL have port wr_ready, output, 1, write accepted when high together with wr_valid.
REQ-009 SHALL have port wr_ch, input, CHW, target entry of the write.
REQ-010 SHALL have port wr_port, input, PORT_W, port_num to store.
REQ-011 SHALL have port wr_inv, input, 1, when high the accepted write invalidates the entry instead of storing wr_port.
REQ-012 SHALL have port clr_req, input, 1, single-cycle pulse starting a table clear.
REQ-013 SHALL have port busy, output, 1, high while a clear sweep runs.
REQ-014 SHALL have port rd_en, input, 1, lookup request.
REQ-015 SHALL have port rd_ch, input, CHW, lookup entry.
REQ-016 SHALL have port rd_out_valid, output, 1, lookup result valid.
REQ-017 SHALL have port rd_port, output, PORT_W, looked-up port_num.
REQ-018 SHALL have port rd_hit, output, 1, looked-up entry valid bit.
REQ-019 SHALL have port valids, output, NUM_CH, per-entry valid bits, registered.
REQ-020 SHALL have port valid_cnt, output, CNTW, population count of valids, registered.
REQ-021 SHALL have port wr_err, output, 1, one-cycle pulse on an accepted write with wr_ch >= NUM_CH.

Function
REQ-022 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req in IDLE; CLEAR->IDLE after index NUM_CH-1 is written; clr_req in CLEAR ignored.
REQ-023 SHALL in CLEAR write one entry per cycle, index 0 upward, to port_num=DEFAULT_PORT, valid=0; sweep takes exactly NUM_CH cycles; busy high for exactly those cycles.
REQ-024 SHALL drive wr_ready = 1 in IDLE and 0 in CLEAR; clr_req and accepted write in the same IDLE cycle: write applied, then clear starts next cycle.
REQ-025 SHALL on accepted write with wr_ch < NUM_CH update the entry at the next edge: wr_inv=0 -> port_num=wr_port, valid=1; wr_inv=1 -> valid=0, port_num unchanged.
REQ-026 SHALL drop an accepted write with wr_ch >= NUM_CH, pulse wr_err next cycle, leave table unchanged.
REQ-027 SHALL give lookups fixed latency 1: rd_out_valid = rd_en delayed one cycle; rd_port/rd_hit reflect entry contents before any same-cycle write (read-before-write).
REQ-028 SHALL return rd_hit=0, rd_port=DEFAULT_PORT for rd_ch >= NUM_CH; lookups are serviced in both states.
REQ-029 SHALL update valids and valid_cnt in the same edge as the entry change, so valid_cnt always equals popcount(valids).
REQ-030 SHALL hold rd_port/rd_hit at last values when rd_out_valid is 0.

Reset
REQ-031 SHALL on res: all entries port_num=DEFAULT_PORT, valid=0; state IDLE; busy, rd_out_valid, rd_hit, wr_err = 0; rd_port = DEFAULT_PORT; valids = 0; valid_cnt = 0; wr_ready = 1 after release.
REQ-032 SHALL abort a clear sweep in progress on res; no partial-sweep state survives.

Verification
REQ-033 SHALL cover: NUM_CH=8, write ch3 port 0xA, rd_en ch3 next cycle -> rd_out_valid=1, rd_port=0xA, rd_hit=1, valid_cnt=1.
REQ-034 SHALL cover: fill all 8 entries, pulse clr_req -> busy high 8 cycles, wr_ready=0 throughout, then valids=0, valid_cnt=0, all rd_port=DEFAULT_PORT.
REQ-035 SHALL cover: write ch5 port 0x3 and rd_en ch5 in same cycle on previously invalid entry -> rd_hit=0; re-read next cycle -> rd_hit=1, rd_port=0x3.
REQ-036 SHALL cover: NUM_CH=6, write wr_ch=7 -> wr_err pulses one cycle, valids unchanged; rd_ch=7 -> rd_hit=0, rd_port=DEFAULT_PORT.
REQ-037 SHALL cover: assert res at cycle 3 of a clear sweep -> busy=0 immediately, state IDLE, valid_cnt=0, subsequent write accepted.

Source files
------------

// File: rtl/port_info_table.sv
// Channel-to-port lookup table: NUM_CH entries of {valid, port_num}.
// Single write port (store or invalidate), one-cycle lookup with
// read-before-write semantics, and a one-entry-per-cycle clear sweep.
// Entries live in flops so the asynchronous reset can restore all of them.
module port_info_table #(
   parameter  int NUM_CH       = 8,
   parameter  int PORT_W       = 4,
   parameter  int DEFAULT_PORT = 0,
   localparam int CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNTW         = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              res,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [CHW-1:0]    wr_ch,
   input  logic [PORT_W-1:0] wr_port,
   input  logic              wr_inv,
   input  logic              clr_req,
   output logic              busy,
   input  logic              rd_en,
   input  logic [CHW-1:0]    rd_ch,
   output logic              rd_out_valid,
   output logic [PORT_W-1:0] rd_port,
   output logic              rd_hit,
   output logic [NUM_CH-1:0] valids,
   output logic [CNTW-1:0]   valid_cnt,
   output logic              wr_err
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [PORT_W-1:0] DEF_PORT = PORT_W'(DEFAULT_PORT);
   localparam logic [CHW-1:0]    LAST_IDX = CHW'(NUM_CH - 1);
   localparam logic [CHW:0]      NUM_CH_W = (CHW + 1)'(NUM_CH);

   state_t            r_state;
   state_t            w_state_next;
   logic [CHW-1:0]    r_clr_idx;
   logic [CHW-1:0]    w_clr_idx_next;

   logic [PORT_W-1:0] r_port [NUM_CH];
   logic [NUM_CH-1:0] r_valids;
   logic [NUM_CH-1:0] w_valids_next;
   logic [CNTW-1:0]   r_valid_cnt;
   logic [CNTW-1:0]   w_cnt_next;

   logic              r_wr_err;
   logic              r_rd_out_valid;
   logic              r_rd_hit;
   logic [PORT_W-1:0] r_rd_port;

   logic              w_wr_acc;
   logic              w_wr_in_range;
   logic              w_rd_in_range;
   logic [CHW-1:0]    w_rd_idx;
   logic [NUM_CH-1:0] w_wr_sel;
   logic [NUM_CH-1:0] w_clr_sel;

   // Writes are only taken while no sweep is running.
   assign w_wr_acc      = wr_valid & (r_state == ST_IDLE);
   assign w_wr_in_range = ({1'b0, wr_ch} < NUM_CH_W);
   assign w_rd_in_range = ({1'b0, rd_ch} < NUM_CH_W);
   // Keep the array index legal even when rd_ch points past the table.
   assign w_rd_idx      = w_rd_in_range ? rd_ch : '0;

   // State register and sweep pointer.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state   <= ST_IDLE;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_state_next;
         r_clr_idx <= w_clr_idx_next;
      end
   end

   // Next-state logic: a clear request in IDLE starts the sweep; the sweep
   // ends after the last index is written. Requests during CLEAR are ignored.
   always_comb begin
      w_state_next   = r_state;
      w_clr_idx_next = r_clr_idx;
      case (r_state)
         ST_IDLE: begin
            w_clr_idx_next = '0;
            if (clr_req) begin
               w_state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (r_clr_idx == LAST_IDX) begin
               w_state_next   = ST_IDLE;
               w_clr_idx_next = '0;
            end else begin
               w_clr_idx_next = r_clr_idx + 1'b1;
            end
         end
         default: begin
            w_state_next   = ST_IDLE;
            w_clr_idx_next = '0;
         end
      endcase
   end

   // Per-entry select and storage. Write and sweep selects never overlap
   // because writes are accepted only in IDLE.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_entry
         assign w_wr_sel[gi]  = w_wr_acc & w_wr_in_range & (wr_ch == CHW'(gi));
         assign w_clr_sel[gi] = (r_state == ST_CLEAR) & (r_clr_idx == CHW'(gi));
         assign w_valids_next[gi] = w_clr_sel[gi] ? 1'b0 :
                                    w_wr_sel[gi]  ? ~wr_inv : r_valids[gi];

         // Entry port_num: cleared by sweep, stored by a non-invalidating write.
         always_ff @(posedge clk or posedge res) begin
            if (res) begin
               r_port[gi] <= DEF_PORT;
            end else if (w_clr_sel[gi]) begin
               r_port[gi] <= DEF_PORT;
            end else if (w_wr_sel[gi] && !wr_inv) begin
               r_port[gi] <= wr_port;
            end
         end
      end
   endgenerate

   // Population count of the next valid vector, so count and bits move together.
   always_comb begin
      w_cnt_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cnt_next = w_cnt_next + CNTW'(w_valids_next[i]);
      end
   end

   // Valid bits, their count and the out-of-range write error pulse.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_valids    <= '0;
         r_valid_cnt <= '0;
         r_wr_err    <= 1'b0;
      end else begin
         r_valids    <= w_valids_next;
         r_valid_cnt <= w_cnt_next;
         r_wr_err    <= w_wr_acc & ~w_wr_in_range;
      end
   end

   // Lookup pipeline: samples current contents, so same-cycle writes are not seen.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_rd_out_valid <= 1'b0;
         r_rd_hit       <= 1'b0;
         r_rd_port      <= DEF_PORT;
      end else begin
         r_rd_out_valid <= rd_en;
         if (rd_en) begin
            r_rd_hit  <= w_rd_in_range & r_valids[w_rd_idx];
            r_rd_port <= w_rd_in_range ? r_port[w_rd_idx] : DEF_PORT;
         end
      end
   end

   assign wr_ready     = (r_state == ST_IDLE);
   assign busy         = (r_state == ST_CLEAR);
   assign rd_out_valid = r_rd_out_valid;
   assign rd_port      = r_rd_port;
   assign rd_hit       = r_rd_hit;
   assign valids       = r_valids;
   assign valid_cnt    = r_valid_cnt;
   assign wr_err       = r_wr_err;

endmodule

// File: tb/tb_port_info_table.sv
// Bench for port_info_table: an 8-entry instance (DEFAULT_PORT=5) and a
// 6-entry instance (DEFAULT_PORT=9). Lookup results go through per-instance
// expectation queues checked by monitors; status outputs are checked directly.
module tb_port_info_table;

   logic clk;
   logic res;

   // 8-entry instance
   logic       a_wr_valid, a_wr_ready, a_wr_inv, a_clr_req, a_busy;
   logic [2:0] a_wr_ch, a_rd_ch;
   logic [3:0] a_wr_port, a_rd_port, a_valid_cnt;
   logic       a_rd_en, a_rd_out_valid, a_rd_hit, a_wr_err;
   logic [7:0] a_valids;

   // 6-entry instance
   logic       b_wr_valid, b_wr_ready, b_wr_inv, b_clr_req, b_busy;
   logic [2:0] b_wr_ch, b_rd_ch, b_valid_cnt;
   logic [3:0] b_wr_port, b_rd_port;
   logic       b_rd_en, b_rd_out_valid, b_rd_hit, b_wr_err;
   logic [5:0] b_valids;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] a_q[$];
   logic [4:0] b_q[$];

   port_info_table #(.NUM_CH(8), .PORT_W(4), .DEFAULT_PORT(5)) u_a (
      .clk(clk), .res(res),
      .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_ch(a_wr_ch),
      .wr_port(a_wr_port), .wr_inv(a_wr_inv), .clr_req(a_clr_req),
      .busy(a_busy), .rd_en(a_rd_en), .rd_ch(a_rd_ch),
      .rd_out_valid(a_rd_out_valid), .rd_port(a_rd_port), .rd_hit(a_rd_hit),
      .valids(a_valids), .valid_cnt(a_valid_cnt), .wr_err(a_wr_err)
   );

   port_info_table #(.NUM_CH(6), .PORT_W(4), .DEFAULT_PORT(9)) u_b (
      .clk(clk), .res(res),
      .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_ch(b_wr_ch),
      .wr_port(b_wr_port), .wr_inv(b_wr_inv), .clr_req(b_clr_req),
      .busy(b_busy), .rd_en(b_rd_en), .rd_ch(b_rd_ch),
      .rd_out_valid(b_rd_out_valid), .rd_port(b_rd_port), .rd_hit(b_rd_hit),
      .valids(b_valids), .valid_cnt(b_valid_cnt), .wr_err(b_wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wr(input int ch, input int port, input logic inv);
      a_wr_valid = 1'b1;
      a_wr_ch    = 3'(ch);
      a_wr_port  = 4'(port);
      a_wr_inv   = inv;
   endtask

   task automatic b_wr(input int ch, input int port, input logic inv);
      b_wr_valid = 1'b1;
      b_wr_ch    = 3'(ch);
      b_wr_port  = 4'(port);
      b_wr_inv   = inv;
   endtask

   task automatic a_rd(input int ch, input int port, input logic hit);
      a_rd_en = 1'b1;
      a_rd_ch = 3'(ch);
      a_q.push_back({hit, 4'(port)});
   endtask

   task automatic b_rd(input int ch, input int port, input logic hit);
      b_rd_en = 1'b1;
      b_rd_ch = 3'(ch);
      b_q.push_back({hit, 4'(port)});
   endtask

   // Lookup monitors: every valid result must match the oldest expectation.
   always @(negedge clk) begin
      logic [4:0] e;
      if (a_rd_out_valid === 1'b1) begin
         if (a_q.size() == 0) begin
            chk("a_rd_unexpected", 32'd1, 32'd0);
         end else begin
            e = a_q.pop_front();
            chk("a_rd_port", 32'(a_rd_port), 32'(e[3:0]));
            chk("a_rd_hit", 32'(a_rd_hit), 32'(e[4]));
         end
      end
   end

   always @(negedge clk) begin
      logic [4:0] e;
      if (b_rd_out_valid === 1'b1) begin
         if (b_q.size() == 0) begin
            chk("b_rd_unexpected", 32'd1, 32'd0);
         end else begin
            e = b_q.pop_front();
            chk("b_rd_port", 32'(b_rd_port), 32'(e[3:0]));
            chk("b_rd_hit", 32'(b_rd_hit), 32'(e[4]));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rdy_bad;
      res = 1'b1;
      a_wr_valid = 0; a_wr_ch = 0; a_wr_port = 0; a_wr_inv = 0; a_clr_req = 0;
      a_rd_en = 0; a_rd_ch = 0;
      b_wr_valid = 0; b_wr_ch = 0; b_wr_port = 0; b_wr_inv = 0; b_clr_req = 0;
      b_rd_en = 0; b_rd_ch = 0;
      repeat (2) tick();

      // Reset values
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_rd_out_valid", 32'(a_rd_out_valid), 0);
      chk("rst_rd_hit", 32'(a_rd_hit), 0);
      chk("rst_rd_port", 32'(a_rd_port), 5);
      chk("rst_valids", 32'(a_valids), 0);
      chk("rst_valid_cnt", 32'(a_valid_cnt), 0);
      chk("rst_wr_err", 32'(a_wr_err), 0);
      chk("rst_b_rd_port", 32'(b_rd_port), 9);
      res = 1'b0;
      tick();
      chk("rst_wr_ready", 32'(a_wr_ready), 1);

      // Write ch3 = 0xA, look it up next cycle
      a_wr(3, 'hA, 0);
      tick();
      a_wr_valid = 0;
      a_rd(3, 'hA, 1);
      tick();
      a_rd_en = 0;
      chk("wr3_valid_cnt", 32'(a_valid_cnt), 1);

      // Same-cycle write and lookup of ch5 sees the old (invalid) contents
      a_wr(5, 'h3, 0);
      a_rd(5, 5, 0);
      tick();
      a_wr_valid = 0;
      a_rd(5, 'h3, 1);
      tick();
      a_rd_en = 0;
      tick();
      chk("hold_rd_out_valid", 32'(a_rd_out_valid), 0);
      chk("hold_rd_port", 32'(a_rd_port), 'h3);
      chk("hold_rd_hit", 32'(a_rd_hit), 1);
      chk("wr5_valids", 32'(a_valids), 'h28);
      chk("wr5_valid_cnt", 32'(a_valid_cnt), 2);

      // Invalidate ch3: valid drops, port_num kept
      a_wr(3, 'hE, 1);
      tick();
      a_wr_valid = 0;
      a_rd(3, 'hA, 0);
      tick();
      a_rd_en = 0;
      chk("inv3_valids", 32'(a_valids), 'h20);
      chk("inv3_valid_cnt", 32'(a_valid_cnt), 1);

      // Fill all eight entries with port i+1
      for (int i = 0; i < 8; i++) begin
         a_wr(i, i + 1, 0);
         tick();
      end
      a_wr_valid = 0;
      chk("fill_valids", 32'(a_valids), 'hFF);
      chk("fill_valid_cnt", 32'(a_valid_cnt), 8);
      a_rd(7, 8, 1);
      tick();
      a_rd_en = 0;

      // Clear together with a write to ch0; the write lands first
      a_wr(0, 'hC, 0);
      a_clr_req = 1'b1;
      tick();
      a_clr_req = 1'b0;
      a_wr(2, 'hF, 0);         // held through the sweep, must not be accepted
      a_rd(0, 'hC, 1);         // sampled in sweep cycle 0, before entry 0 is cleared
      n = 0;
      rdy_bad = 0;
      while (a_busy === 1'b1 && n < 20) begin
         if (a_wr_ready !== 1'b0) rdy_bad++;
         a_clr_req = (n == 2);  // ignored while sweeping
         n++;
         tick();
         a_rd_en = 0;
      end
      a_wr_valid = 0;
      a_clr_req = 0;
      chk("clr_busy_cycles", 32'(n), 8);
      chk("clr_ready_low", 32'(rdy_bad), 0);
      chk("clr_valids", 32'(a_valids), 0);
      chk("clr_valid_cnt", 32'(a_valid_cnt), 0);
      chk("clr_wr_ready", 32'(a_wr_ready), 1);
      for (int i = 0; i < 8; i++) begin
         a_rd(i, 5, 0);
         tick();
      end
      a_rd_en = 0;
      tick();

      // Reset in the middle of a sweep
      a_wr(1, 7, 0);
      tick();
      a_wr_valid = 0;
      chk("pre_abort_cnt", 32'(a_valid_cnt), 1);
      a_clr_req = 1'b1;
      tick();
      a_clr_req = 1'b0;
      chk("abort_busy_before", 32'(a_busy), 1);
      tick();
      tick();
      #2;
      res = 1'b1;
      #1;
      chk("abort_busy", 32'(a_busy), 0);
      chk("abort_wr_ready", 32'(a_wr_ready), 1);
      chk("abort_valid_cnt", 32'(a_valid_cnt), 0);
      chk("abort_valids", 32'(a_valids), 0);
      #2;
      res = 1'b0;
      a_wr(6, 'hB, 0);
      tick();
      a_wr_valid = 0;
      chk("post_abort_valids", 32'(a_valids), 'h40);
      chk("post_abort_cnt", 32'(a_valid_cnt), 1);
      a_rd(6, 'hB, 1);
      tick();
      a_rd(1, 5, 0);
      tick();
      a_rd_en = 0;
      tick();

      // Six-entry instance: out-of-range writes and lookups
      b_wr(2, 4, 0);
      tick();
      b_wr_valid = 0;
      chk("b_wr2_valids", 32'(b_valids), 'h04);
      chk("b_wr2_err", 32'(b_wr_err), 0);
      b_wr(7, 1, 0);
      tick();
      b_wr_valid = 0;
      chk("b_wr7_err", 32'(b_wr_err), 1);
      chk("b_wr7_valids", 32'(b_valids), 'h04);
      chk("b_wr7_cnt", 32'(b_valid_cnt), 1);
      tick();
      chk("b_err_pulse_end", 32'(b_wr_err), 0);
      b_wr(6, 1, 0);
      tick();
      b_wr_valid = 0;
      chk("b_wr6_err", 32'(b_wr_err), 1);
      chk("b_wr6_valids", 32'(b_valids), 'h04);
      b_rd(7, 9, 0);
      tick();
      b_rd(2, 4, 1);
      tick();
      b_rd(5, 9, 0);
      tick();
      b_rd_en = 0;
      repeat (3) tick();

      chk("a_queue_drained", 32'(a_q.size()), 0);
      chk("b_queue_drained", 32'(b_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
